// File: rtl/axi_xbar_pkg.sv
// Shared constants for the AXI crossbar: target region codes, response and
// burst encodings, and the DECERR responder state type.
package axi_xbar_pkg;

    // Number of address bits used to select a region (top bits of araddr).
    localparam int REGION_W = 2;

    // Region codes produced by the address decode.
    localparam logic [1:0] TGT_S0     = 2'd0;
    localparam logic [1:0] TGT_S1     = 2'd1;
    localparam logic [1:0] TGT_S2     = 2'd2;
    localparam logic [1:0] TGT_DECERR = 2'd3;

    localparam int NUM_SLAVES = 3;

    // AXI response codes.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // AXI burst type codes.
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic {
        DECERR_IDLE = 1'b0,
        DECERR_RESP = 1'b1
    } decerr_state_t;

    // Bit position of the region field's MSB for a given address width.
    function automatic int region_msb(input int addr_w);
        return addr_w - 1;
    endfunction

endpackage

// File: rtl/read_address_decoder_decerr_responder.sv
// Internal responder for unmapped reads: emits arlen+1 DECERR beats on the
// R side and signals completion on the last accepted beat.
module decerr_responder #(
    parameter int ID_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req,
    input  logic [7:0]      arlen,
    input  logic [ID_W-1:0] arid,
    output logic            load,
    output logic [ID_W-1:0] rid,
    output logic            rvalid,
    output logic            rlast,
    input  logic            rready,
    output logic            done
);
    import axi_xbar_pkg::*;

    decerr_state_t   state_reg, state_next;
    logic [7:0]      beats_reg, beats_next;
    logic [ID_W-1:0] rid_reg, rid_next;

    // State, remaining-beat counter and response ID registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= DECERR_IDLE;
            beats_reg <= '0;
            rid_reg   <= '0;
        end else begin
            state_reg <= state_next;
            beats_reg <= beats_next;
            rid_reg   <= rid_next;
        end
    end

    // Next state: load a burst from IDLE, count beats down in RESP.
    always_comb begin
        state_next = state_reg;
        beats_next = beats_reg;
        rid_next   = rid_reg;
        load       = 1'b0;
        rvalid     = 1'b0;
        rlast      = 1'b0;
        done       = 1'b0;
        case (state_reg)
            DECERR_IDLE: begin
                if (req) begin
                    load       = 1'b1;
                    state_next = DECERR_RESP;
                    beats_next = arlen;
                    rid_next   = arid;
                end
            end
            DECERR_RESP: begin
                rvalid = 1'b1;
                rlast  = (beats_reg == 8'd0);
                if (rready) begin
                    if (beats_reg == 8'd0) begin
                        done       = 1'b1;
                        state_next = DECERR_IDLE;
                    end else begin
                        beats_next = beats_reg - 8'd1;
                    end
                end
            end
            default: state_next = DECERR_IDLE;
        endcase
    end

    assign rid = rid_reg;

endmodule

// File: rtl/read_address_decoder.sv
// Per-master AR front end: decodes the target region, holds one AR beat in a
// register slice toward the selected arbiter, and keeps all in-flight reads on
// a single target so this master's R data stays in order.
module read_address_decoder #(
    parameter int ADDR_W          = 12,
    parameter int ID_W            = 6,
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_W           = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic [7:0]        s_axi_arlen,
    input  logic [2:0]        s_axi_arsize,
    input  logic [1:0]        s_axi_arburst,
    input  logic [ID_W-1:0]   s_axi_arid,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [ADDR_W-1:0] ar_decoder_araddr_s0,
    output logic [7:0]        ar_decoder_arlen_s0,
    output logic [2:0]        ar_decoder_arsize_s0,
    output logic [1:0]        ar_decoder_arburst_s0,
    output logic [ID_W-1:0]   ar_decoder_arid_s0,
    output logic              ar_decoder_valid_s0,
    input  logic              ar_decoder_ready_s0,
    output logic [ADDR_W-1:0] ar_decoder_araddr_s1,
    output logic [7:0]        ar_decoder_arlen_s1,
    output logic [2:0]        ar_decoder_arsize_s1,
    output logic [1:0]        ar_decoder_arburst_s1,
    output logic [ID_W-1:0]   ar_decoder_arid_s1,
    output logic              ar_decoder_valid_s1,
    input  logic              ar_decoder_ready_s1,
    output logic [ADDR_W-1:0] ar_decoder_araddr_s2,
    output logic [7:0]        ar_decoder_arlen_s2,
    output logic [2:0]        ar_decoder_arsize_s2,
    output logic [1:0]        ar_decoder_arburst_s2,
    output logic [ID_W-1:0]   ar_decoder_arid_s2,
    output logic              ar_decoder_valid_s2,
    input  logic              ar_decoder_ready_s2,
    input  logic              r_done,
    output logic [1:0]        r_sel,
    output logic              r_sel_valid,
    output logic [ID_W-1:0]   decerr_rid,
    output logic              decerr_rvalid,
    output logic              decerr_rlast,
    input  logic              decerr_rready
);
    import axi_xbar_pkg::*;

    localparam int TGT_MSB = region_msb(ADDR_W);

    // Held AR beat (1-deep register slice).
    logic              pending_valid_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [7:0]        len_reg;
    logic [2:0]        size_reg;
    logic [1:0]        burst_reg;
    logic [ID_W-1:0]   id_reg;
    logic [1:0]        sel_reg;

    // Outstanding-read tracking.
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [1:0]        r_sel_reg;
    // Holds arready low for the first cycle after reset release.
    logic              init_reg;

    logic [1:0]            tgt;
    logic                  stall;
    logic                  accept;
    logic                  out_hs;
    logic                  decerr_load;
    logic                  decerr_done;
    logic [NUM_SLAVES-1:0] slave_ready;
    logic [NUM_SLAVES-1:0] slave_valid;

    assign tgt = s_axi_araddr[TGT_MSB -: REGION_W];

    assign slave_ready = {ar_decoder_ready_s2, ar_decoder_ready_s1, ar_decoder_ready_s0};

    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave_valid
            assign slave_valid[gi] = pending_valid_reg && (sel_reg == 2'(gi));
        end
    endgenerate

    // The held beat leaves either through its arbiter or into the DECERR FSM.
    assign out_hs = (|(slave_valid & slave_ready)) || decerr_load;

    // Never exceed the outstanding limit and never switch target mid-flight.
    assign stall = (count_reg == CNT_W'(MAX_OUTSTANDING)) ||
                   ((count_reg != '0) && (tgt != r_sel_reg));

    assign s_axi_arready = init_reg && !stall && (!pending_valid_reg || out_hs);
    assign accept        = s_axi_arvalid && s_axi_arready;

    // Reset-release gate for arready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            init_reg <= 1'b0;
        end else begin
            init_reg <= 1'b1;
        end
    end

    // Register slice: load on accept, empty when the held beat is issued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_valid_reg <= 1'b0;
            sel_reg           <= TGT_S0;
        end else if (accept) begin
            pending_valid_reg <= 1'b1;
            sel_reg           <= tgt;
        end else if (out_hs) begin
            pending_valid_reg <= 1'b0;
        end
    end

    // Payload is not reset; it is only observed while pending_valid_reg is set.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_reg  <= s_axi_araddr;
            len_reg   <= s_axi_arlen;
            size_reg  <= s_axi_arsize;
            burst_reg <= s_axi_arburst;
            id_reg    <= s_axi_arid;
        end
    end

    // Outstanding count: +1 per accept, -1 per completion (external or DECERR).
    always_comb begin
        count_next = count_reg;
        if (accept && !(r_done || decerr_done)) begin
            count_next = count_reg + 1'b1;
        end else if (!accept && (r_done || decerr_done)) begin
            count_next = count_reg - 1'b1;
        end
    end

    // Outstanding count and R-mux selection; r_sel keeps its value at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
            r_sel_reg <= TGT_S0;
        end else begin
            count_reg <= count_next;
            if (accept) begin
                r_sel_reg <= tgt;
            end
        end
    end

    decerr_responder #(
        .ID_W (ID_W)
    ) u_decerr (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (pending_valid_reg && (sel_reg == TGT_DECERR)),
        .arlen  (len_reg),
        .arid   (id_reg),
        .load   (decerr_load),
        .rid    (decerr_rid),
        .rvalid (decerr_rvalid),
        .rlast  (decerr_rlast),
        .rready (decerr_rready),
        .done   (decerr_done)
    );

    assign r_sel       = r_sel_reg;
    assign r_sel_valid = (count_reg != '0);

    assign ar_decoder_valid_s0 = slave_valid[0];
    assign ar_decoder_valid_s1 = slave_valid[1];
    assign ar_decoder_valid_s2 = slave_valid[2];

    assign ar_decoder_araddr_s0  = addr_reg;
    assign ar_decoder_arlen_s0   = len_reg;
    assign ar_decoder_arsize_s0  = size_reg;
    assign ar_decoder_arburst_s0 = burst_reg;
    assign ar_decoder_arid_s0    = id_reg;
    assign ar_decoder_araddr_s1  = addr_reg;
    assign ar_decoder_arlen_s1   = len_reg;
    assign ar_decoder_arsize_s1  = size_reg;
    assign ar_decoder_arburst_s1 = burst_reg;
    assign ar_decoder_arid_s1    = id_reg;
    assign ar_decoder_araddr_s2  = addr_reg;
    assign ar_decoder_arlen_s2   = len_reg;
    assign ar_decoder_arsize_s2  = size_reg;
    assign ar_decoder_arburst_s2 = burst_reg;
    assign ar_decoder_arid_s2    = id_reg;

    // A completion with nothing outstanding means the R side is out of sync.
    r_done_legal: assert property (@(posedge clk) disable iff (!rst_n)
                                   !(r_done && (count_reg == '0)));

endmodule

// File: tb/tb_read_address_decoder.sv
// Bench for read_address_decoder: decode table, directed multi-cycle
// sequences and randomized traffic, all checked every cycle against a
// transaction-level model of the decoder.
module tb_read_address_decoder;

    localparam int ADDR_W = 12;
    localparam int ID_W   = 6;
    localparam int MAXO   = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] s_axi_araddr;
    logic [7:0]        s_axi_arlen;
    logic [2:0]        s_axi_arsize;
    logic [1:0]        s_axi_arburst;
    logic [ID_W-1:0]   s_axi_arid;
    logic              s_axi_arvalid;
    logic              s_axi_arready;
    logic [ADDR_W-1:0] araddr_s0, araddr_s1, araddr_s2;
    logic [7:0]        arlen_s0, arlen_s1, arlen_s2;
    logic [2:0]        arsize_s0, arsize_s1, arsize_s2;
    logic [1:0]        arburst_s0, arburst_s1, arburst_s2;
    logic [ID_W-1:0]   arid_s0, arid_s1, arid_s2;
    logic              valid_s0, valid_s1, valid_s2;
    logic              ready_s0, ready_s1, ready_s2;
    logic              r_done;
    logic [1:0]        r_sel;
    logic              r_sel_valid;
    logic [ID_W-1:0]   decerr_rid;
    logic              decerr_rvalid;
    logic              decerr_rlast;
    logic              decerr_rready;

    always #5 clk = ~clk;

    read_address_decoder dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .s_axi_araddr          (s_axi_araddr),
        .s_axi_arlen           (s_axi_arlen),
        .s_axi_arsize          (s_axi_arsize),
        .s_axi_arburst         (s_axi_arburst),
        .s_axi_arid            (s_axi_arid),
        .s_axi_arvalid         (s_axi_arvalid),
        .s_axi_arready         (s_axi_arready),
        .ar_decoder_araddr_s0  (araddr_s0),
        .ar_decoder_arlen_s0   (arlen_s0),
        .ar_decoder_arsize_s0  (arsize_s0),
        .ar_decoder_arburst_s0 (arburst_s0),
        .ar_decoder_arid_s0    (arid_s0),
        .ar_decoder_valid_s0   (valid_s0),
        .ar_decoder_ready_s0   (ready_s0),
        .ar_decoder_araddr_s1  (araddr_s1),
        .ar_decoder_arlen_s1   (arlen_s1),
        .ar_decoder_arsize_s1  (arsize_s1),
        .ar_decoder_arburst_s1 (arburst_s1),
        .ar_decoder_arid_s1    (arid_s1),
        .ar_decoder_valid_s1   (valid_s1),
        .ar_decoder_ready_s1   (ready_s1),
        .ar_decoder_araddr_s2  (araddr_s2),
        .ar_decoder_arlen_s2   (arlen_s2),
        .ar_decoder_arsize_s2  (arsize_s2),
        .ar_decoder_arburst_s2 (arburst_s2),
        .ar_decoder_arid_s2    (arid_s2),
        .ar_decoder_valid_s2   (valid_s2),
        .ar_decoder_ready_s2   (ready_s2),
        .r_done                (r_done),
        .r_sel                 (r_sel),
        .r_sel_valid           (r_sel_valid),
        .decerr_rid            (decerr_rid),
        .decerr_rvalid         (decerr_rvalid),
        .decerr_rlast          (decerr_rlast),
        .decerr_rready         (decerr_rready)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Reference model: transaction-level view of the decoder.
    bit              m_init;
    int              m_count;      // reads accepted, not completed
    int              m_issued;     // reads handed to a slave, awaiting r_done
    logic [1:0]      m_rsel;
    bit              m_pv;         // a beat is waiting for issue
    logic [11:0]     m_paddr;
    logic [7:0]      m_plen;
    logic [2:0]      m_psize;
    logic [1:0]      m_pburst;
    logic [ID_W-1:0] m_pid;
    logic [1:0]      m_ptgt;
    bit              m_dbusy;      // DECERR burst in progress
    int              m_dleft;      // DECERR beats still to send
    logic [ID_W-1:0] m_drid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_init = 0; m_count = 0; m_issued = 0; m_rsel = 2'd0; m_pv = 0;
        m_dbusy = 0; m_dleft = 0; m_drid = '0; m_ptgt = 2'd0;
    endtask

    // One clock: check outputs at the falling edge, advance model at the rising edge.
    task automatic tick();
        logic [1:0] tin;
        logic [2:0] rv;
        bit stall, ohs, e_rdy, acc, dn;
        @(negedge clk);
        tin   = s_axi_araddr[11:10];
        rv    = {ready_s2, ready_s1, ready_s0};
        stall = (m_count == MAXO) || (m_count != 0 && tin != m_rsel);
        ohs   = m_pv && ((m_ptgt == 2'd3) ? !m_dbusy : rv[m_ptgt]);
        e_rdy = m_init && !stall && (!m_pv || ohs);
        if (chk_en) begin
            chk("arready", {31'd0, s_axi_arready}, {31'd0, e_rdy});
            chk("valid_s0", {31'd0, valid_s0}, {31'd0, m_pv && m_ptgt == 2'd0});
            chk("valid_s1", {31'd0, valid_s1}, {31'd0, m_pv && m_ptgt == 2'd1});
            chk("valid_s2", {31'd0, valid_s2}, {31'd0, m_pv && m_ptgt == 2'd2});
            chk("decerr_rvalid", {31'd0, decerr_rvalid}, {31'd0, m_dbusy});
            chk("r_sel_valid", {31'd0, r_sel_valid}, {31'd0, m_count != 0});
            chk("r_sel", {30'd0, r_sel}, {30'd0, m_rsel});
            if (m_dbusy) begin
                chk("decerr_rlast", {31'd0, decerr_rlast}, {31'd0, m_dleft == 1});
                chk("decerr_rid", {26'd0, decerr_rid}, {26'd0, m_drid});
            end
            if (m_pv && m_ptgt != 2'd3) begin
                chk("araddr_s0", {20'd0, araddr_s0}, {20'd0, m_paddr});
                chk("araddr_s1", {20'd0, araddr_s1}, {20'd0, m_paddr});
                chk("arid_s2", {26'd0, arid_s2}, {26'd0, m_pid});
                chk("arlen_s1", {24'd0, arlen_s1}, {24'd0, m_plen});
                chk("arsize_s2", {29'd0, arsize_s2}, {29'd0, m_psize});
                chk("arburst_s0", {30'd0, arburst_s0}, {30'd0, m_pburst});
            end
        end
        acc = s_axi_arvalid && e_rdy;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            dn = m_dbusy && decerr_rready && (m_dleft == 1);
            if (m_dbusy && decerr_rready) begin
                m_dleft--;
                if (m_dleft == 0) m_dbusy = 0;
            end
            if (ohs && m_ptgt == 2'd3) begin
                m_dbusy = 1; m_dleft = int'(m_plen) + 1; m_drid = m_pid;
            end
            if (ohs && m_ptgt != 2'd3) m_issued++;
            if (r_done) m_issued--;
            m_count = m_count + int'(acc) - int'(r_done) - int'(dn);
            if (acc) begin
                m_rsel = tin; m_pv = 1; m_ptgt = tin;
                m_paddr = s_axi_araddr; m_plen = s_axi_arlen; m_psize = s_axi_arsize;
                m_pburst = s_axi_arburst; m_pid = s_axi_arid;
                $display("AR accept addr=%03h len=%0d id=%02h tgt=%0d", s_axi_araddr,
                         s_axi_arlen, s_axi_arid, tin);
            end else if (ohs) begin
                m_pv = 0;
            end
            m_init = 1;
        end
        #1;
    endtask

    task automatic set_ar(input logic [11:0] a, input logic [7:0] len, input logic [ID_W-1:0] id);
        s_axi_arvalid = 1'b1; s_axi_araddr = a; s_axi_arlen = len; s_axi_arid = id;
        s_axi_arsize = 3'd2; s_axi_arburst = 2'b01;
    endtask

    // Complete everything in flight, with a bounded wait.
    task automatic drain();
        int guard = 0;
        s_axi_arvalid = 1'b0; decerr_rready = 1'b1;
        ready_s0 = 1'b1; ready_s1 = 1'b1; ready_s2 = 1'b1;
        while ((m_count != 0 || m_pv) && guard < 300) begin
            r_done = (m_issued > 0);
            tick();
            guard++;
        end
        r_done = 1'b0;
        if (guard >= 300) begin
            n_cmp++; n_fail++;
            $display("FAIL drain_timeout actual=%0d required=<300", guard);
        end
        chk("drain_rsv", {31'd0, r_sel_valid}, 32'd0);
    endtask

    typedef struct {
        logic [11:0] addr;
        logic [1:0]  exp_tgt;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats, last_at, nlast, rid_bad, vs;
        vecs[0] = '{12'h000, 2'd0};
        vecs[1] = '{12'h3FF, 2'd0};
        vecs[2] = '{12'h400, 2'd1};
        vecs[3] = '{12'h7FF, 2'd1};
        vecs[4] = '{12'h800, 2'd2};
        vecs[5] = '{12'hBFF, 2'd2};
        vecs[6] = '{12'hC00, 2'd3};
        vecs[7] = '{12'hFFF, 2'd3};

        rst_n = 1'b0; s_axi_arvalid = 1'b0; s_axi_araddr = '0; s_axi_arlen = '0;
        s_axi_arsize = '0; s_axi_arburst = '0; s_axi_arid = '0;
        ready_s0 = 1'b0; ready_s1 = 1'b0; ready_s2 = 1'b0;
        r_done = 1'b0; decerr_rready = 1'b0;
        model_reset();
        tick(); tick();
        chk_en = 1'b1;
        tick();
        chk("rst_arready", {31'd0, s_axi_arready}, 32'd0);
        chk("rst_decerr_rvalid", {31'd0, decerr_rvalid}, 32'd0);
        rst_n = 1'b1;
        #1 chk("rel_arready", {31'd0, s_axi_arready}, 32'd0);
        tick();
        chk("post_rel_arready", {31'd0, s_axi_arready}, 32'd1);

        // Decode table.
        for (int i = 0; i < 8; i++) begin
            ready_s0 = 1'b1; ready_s1 = 1'b1; ready_s2 = 1'b1; decerr_rready = 1'b1;
            set_ar(vecs[i].addr, 8'd0, ID_W'(i));
            tick();
            s_axi_arvalid = 1'b0;
            chk("tbl_rsel", {30'd0, r_sel}, {30'd0, vecs[i].exp_tgt});
            chk("tbl_onehot", {29'd0, valid_s2, valid_s1, valid_s0},
                (vecs[i].exp_tgt == 2'd3) ? 32'd0 : (32'd1 << vecs[i].exp_tgt));
            tick();
            chk("tbl_decerr", {31'd0, decerr_rvalid}, {31'd0, vecs[i].exp_tgt == 2'd3});
            if (vecs[i].exp_tgt == 2'd3) chk("tbl_rlast", {31'd0, decerr_rlast}, 32'd1);
            drain();
        end

        // Back-to-back to slave 0.
        ready_s0 = 1'b1;
        set_ar(12'h010, 8'd1, 6'h01); tick();
        set_ar(12'h020, 8'd1, 6'h02); tick();
        set_ar(12'h030, 8'd1, 6'h03); tick();
        s_axi_arvalid = 1'b0;
        tick(); tick();
        chk("t1_rsel", {30'd0, r_sel}, 32'd0);
        chk("t1_rsv", {31'd0, r_sel_valid}, 32'd1);
        r_done = 1'b1; tick(); tick(); tick();
        r_done = 1'b0;
        chk("t1_rsv_done", {31'd0, r_sel_valid}, 32'd0);

        // Target switch blocked until the slave-0 read completes.
        ready_s0 = 1'b1; ready_s1 = 1'b1;
        set_ar(12'h010, 8'd0, 6'h05); tick();
        s_axi_arvalid = 1'b0; tick();
        set_ar(12'h400, 8'd0, 6'h06);
        #1 chk("t2_stall", {31'd0, s_axi_arready}, 32'd0);
        tick(); tick();
        r_done = 1'b1; tick();
        r_done = 1'b0;
        #1 chk("t2_accept", {31'd0, s_axi_arready}, 32'd1);
        tick();
        s_axi_arvalid = 1'b0;
        chk("t2_rsel", {30'd0, r_sel}, 32'd1);
        chk("t2_valid_s1", {31'd0, valid_s1}, 32'd1);
        tick();
        drain();

        // Outstanding limit on slave 2.
        ready_s2 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_ar(12'h800 + 12'(i * 16), 8'd0, ID_W'(i));
            tick();
        end
        set_ar(12'h8F0, 8'd0, 6'h09);
        #1 chk("t3_stall", {31'd0, s_axi_arready}, 32'd0);
        tick(); tick();
        r_done = 1'b1; tick();
        r_done = 1'b0;
        #1 chk("t3_resume", {31'd0, s_axi_arready}, 32'd1);
        tick();
        s_axi_arvalid = 1'b0;
        drain();

        // DECERR burst of four beats.
        decerr_rready = 1'b1;
        set_ar(12'hC00, 8'd3, 6'h2A); tick();
        s_axi_arvalid = 1'b0;
        beats = 0; last_at = 0; nlast = 0; rid_bad = 0; vs = 0;
        for (int i = 0; i < 12; i++) begin
            if (decerr_rvalid) begin
                beats++;
                if (decerr_rlast) begin last_at = beats; nlast++; end
                if (decerr_rid !== 6'h2A) rid_bad++;
            end
            if (valid_s0 || valid_s1 || valid_s2) vs++;
            tick();
        end
        chk("t4_beats", 32'(beats), 32'd4);
        chk("t4_last_at", 32'(last_at), 32'd4);
        chk("t4_nlast", 32'(nlast), 32'd1);
        chk("t4_rid_bad", 32'(rid_bad), 32'd0);
        chk("t4_slave_valid", 32'(vs), 32'd0);
        chk("t4_rsv", {31'd0, r_sel_valid}, 32'd0);

        // Backpressure on slave 1, then accept together with r_done.
        ready_s1 = 1'b0;
        set_ar(12'h450, 8'd2, 6'h11); tick();
        s_axi_arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t5_valid_s1", {31'd0, valid_s1}, 32'd1);
            chk("t5_addr_s1", {20'd0, araddr_s1}, 32'h450);
            tick();
        end
        ready_s1 = 1'b1; tick();
        set_ar(12'h460, 8'd0, 6'h12); r_done = 1'b1;
        #1 chk("t5_arready", {31'd0, s_axi_arready}, 32'd1);
        tick();
        s_axi_arvalid = 1'b0; r_done = 1'b0;
        chk("t5_rsv_same", {31'd0, r_sel_valid}, 32'd1);
        tick();
        r_done = 1'b1; tick();
        r_done = 1'b0;
        chk("t5_rsv_zero", {31'd0, r_sel_valid}, 32'd0);

        // Reset in the middle of a DECERR burst.
        decerr_rready = 1'b1;
        set_ar(12'hC00, 8'd3, 6'h15); tick();
        s_axi_arvalid = 1'b0; tick(); tick();
        chk("t6_mid_burst", {31'd0, decerr_rvalid}, 32'd1);
        rst_n = 1'b0; tick();
        chk("t6_rvalid", {31'd0, decerr_rvalid}, 32'd0);
        chk("t6_rsv", {31'd0, r_sel_valid}, 32'd0);
        chk("t6_arready_rst", {31'd0, s_axi_arready}, 32'd0);
        rst_n = 1'b1;
        #1 chk("t6_arready_rel", {31'd0, s_axi_arready}, 32'd0);
        tick();
        chk("t6_arready_back", {31'd0, s_axi_arready}, 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            s_axi_arvalid = 1'($urandom_range(0, 1));
            s_axi_araddr  = 12'($urandom);
            s_axi_arlen   = 8'($urandom_range(0, 3));
            s_axi_arsize  = 3'($urandom);
            s_axi_arburst = 2'($urandom_range(0, 2));
            s_axi_arid    = ID_W'($urandom);
            ready_s0      = ($urandom_range(0, 3) != 0);
            ready_s1      = ($urandom_range(0, 3) != 0);
            ready_s2      = ($urandom_range(0, 3) != 0);
            decerr_rready = 1'($urandom_range(0, 1));
            r_done        = (m_issued > 0) && ($urandom_range(0, 2) == 0);
            tick();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
